theta_col_controller: RTL and testbench



---
 rtl/theta_col_controller_pkg.sv | 22 ++
 rtl/theta_slice.sv | 38 +++
 rtl/theta_col_controller.sv | 138 +++++++++++++
 tb/tb_theta_col_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/theta_col_controller_pkg.sv
// Shared definitions for the theta column controller: default geometry,
// FSM state encoding and the slice bit-position mapping.
package theta_col_controller_pkg;

    localparam int N_DEF      = 25;
    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_FILL = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bit (x,y) of an n-bit slice sits at position n-1-(5y+x).
    function automatic int bit_pos(input int n, input int x, input int y);
        return n - 1 - (5 * y + x);
    endfunction

endpackage

// File: rtl/theta_slice.sv
// Combinational theta on one 25-bit slice: five column parities of the
// incoming slice (Ccur) plus the column-mix using the previous slice's
// parities (Cprev).
module theta_slice
    import theta_col_controller_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] slice_in,
    input  logic [4:0]   cprev,
    output logic [N-1:0] slice_out,
    output logic [4:0]   ccur
);

    // Column parity reductions: C[x] = XOR over y of bit(x,y).
    always_comb begin
        ccur = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                ccur[x] = ccur[x] ^ slice_in[bit_pos(N, x, y)];
            end
        end
    end

    // Each bit picks up the left neighbour column of this slice and the
    // right neighbour column of the previous slice.
    always_comb begin
        slice_out = slice_in;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                slice_out[bit_pos(N, x, y)] = slice_in[bit_pos(N, x, y)]
                                            ^ ccur[(x + 4) % 5]
                                            ^ cprev[(x + 1) % 5];
            end
        end
    end

endmodule

// File: rtl/theta_col_controller.sv
// Theta step sequencer: streams slices DEPTH-1, 0..DEPTH-1 from a 1-cycle
// synchronous slice memory, carries the previous slice's column parities
// and writes each theta-applied slice to a separate write port.
// Optional build macro THETA_BYPASS_EN adds a 'bypass' input (sampled at
// start accept) that writes slices back unchanged with identical timing.
module theta_col_controller
    import theta_col_controller_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef THETA_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [N-1:0]      mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [N-1:0]      mem_wr_data,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_W = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] z_p0;        // index of the slice arriving on mem_rd_data
    logic [4:0]        cprev_p1;    // parities of slice (z-1) mod DEPTH
    logic [4:0]        ccur_p0;
    logic [N-1:0]      theta_p0;
    logic [N-1:0]      wr_data_p0;
    logic [ADDR_W:0]   rd_next;

    theta_slice #(.N(N)) u_slice (
        .slice_in  (mem_rd_data),
        .cprev     (cprev_p1),
        .slice_out (theta_p0),
        .ccur      (ccur_p0)
    );

    // Read address two slices ahead of the one arriving now.
    always_comb begin
        rd_next = {1'b0, z_p0} + (ADDR_W + 1)'(2);
    end

`ifdef THETA_BYPASS_EN
    logic bypass_q;

    // Bypass selects the raw read slice instead of the theta result.
    always_comb begin
        wr_data_p0 = bypass_q ? mem_rd_data : theta_p0;
    end
`else
    // Theta result always goes to the write port.
    always_comb begin
        wr_data_p0 = theta_p0;
    end
`endif

    // Sequencer FSM with registered strobes, addresses and write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            cprev_p1    <= '0;
            z_p0        <= '0;
`ifdef THETA_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (start) begin
                        ready       <= 1'b0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= LAST_A;
`ifdef THETA_BYPASS_EN
                        bypass_q    <= bypass;
`endif
                        state       <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    mem_rd_addr <= '0;
                    state       <= ST_FILL;
                end
                ST_FILL: begin
                    // Slice DEPTH-1 arrives: its parities are the z-1 term of slice 0.
                    cprev_p1    <= ccur_p0;
                    mem_rd_addr <= ADDR_W'(1);
                    z_p0        <= '0;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= z_p0;
                    mem_wr_data <= wr_data_p0;
                    cprev_p1    <= ccur_p0;
                    if (rd_next <= LAST_W) begin
                        mem_rd_addr <= rd_next[ADDR_W-1:0];
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                    if (z_p0 == LAST_A) begin
                        z_p0  <= '0;
                        state <= ST_DONE;
                    end else begin
                        z_p0 <= z_p0 + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theta_col_controller.sv
// Scoreboard bench for theta_col_controller: stimulus pushes expected
// writes/checks into queues, a negedge monitor pops and compares.
module tb_theta_col_controller;

    localparam int N      = 25;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [N-1:0]      mem_rd_data = '0;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [N-1:0]      mem_wr_data;
    logic              done;
`ifdef THETA_BYPASS_EN
    logic              bypass = 1'b0;
`endif

    theta_col_controller #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef THETA_BYPASS_EN
        .bypass      (bypass),
`endif
        .ready       (ready),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
        logic [31:0]       cyc;
    } wr_exp_t;

    wr_exp_t     sb[$];
    string       chk_name[$];
    logic [31:0] chk_act[$];
    logic [31:0] chk_exp[$];

    logic [N-1:0] mem   [DEPTH];
    logic [N-1:0] exp_w [DEPTH];
    logic [31:0]  cyc = 0;
    logic [31:0]  exp_done = 0;
    int           done_cnt = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  t0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read slice memory model.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Monitor: compare writes, done pulses and posted checks.
    always @(negedge clk) begin
        wr_exp_t e;
        if (mem_wr_en) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected got addr=%0d data=%h cyc=%0d need no write",
                         mem_wr_addr, mem_wr_data, cyc);
            end else begin
                e = sb.pop_front();
                if (mem_wr_addr !== e.addr || mem_wr_data !== e.data || cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL wr_slice got addr=%0d data=%h cyc=%0d need addr=%0d data=%h cyc=%0d",
                             mem_wr_addr, mem_wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
        if (done) begin
            done_cnt++;
            n_vec++;
            if (cyc !== exp_done) begin
                n_err++;
                $display("FAIL done_time got cyc=%0d need cyc=%0d", cyc, exp_done);
            end
        end
        while (chk_name.size() > 0) begin
            string       nm;
            logic [31:0] a;
            logic [31:0] x;
            nm = chk_name.pop_front();
            a  = chk_act.pop_front();
            x  = chk_exp.pop_front();
            n_vec++;
            if (a !== x) begin
                n_err++;
                $display("FAIL %s got %0h need %0h", nm, a, x);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        chk_name.push_back(nm);
        chk_act.push_back(act);
        chk_exp.push_back(expv);
    endtask

    task automatic clear_mem();
        for (int z = 0; z < DEPTH; z++) begin
            mem[z]   = '0;
            exp_w[z] = '0;
        end
    endtask

    // Pulse start while idle; t0 is the cycle count after the accept edge.
    task automatic do_start();
        @(negedge clk);
        check("ready_before_start", {31'd0, ready}, 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        for (int z = 0; z < DEPTH; z++) begin
            sb.push_back('{addr: ADDR_W'(z), data: exp_w[z], cyc: t0 + 32'(z) + 32'd3});
        end
        exp_done = t0 + 32'(DEPTH) + 32'd3;
    endtask

    task automatic finish_run(input string tag);
        bit seen;
        int d0;
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0 + (seen ? 0 : 1)), 32'd1);
        check({tag, "_writes_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
        check({tag, "_rd_en_after"}, {31'd0, mem_rd_en}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready",   {31'd0, ready},      32'd1);
        check("rst_done",    {31'd0, done},       32'd0);
        check("rst_rd_en",   {31'd0, mem_rd_en},  32'd0);
        check("rst_wr_en",   {31'd0, mem_wr_en},  32'd0);
        check("rst_rd_addr", 32'(mem_rd_addr),    32'd0);
        check("rst_wr_addr", 32'(mem_wr_addr),    32'd0);
        check("rst_wr_data", 32'(mem_wr_data),    32'd0);

        // All-zero state.
        clear_mem();
        do_start();
        finish_run("zero");

        // Single bit (0,0) in slice 0.
        clear_mem();
        mem[0]   = 25'h1000000;
        exp_w[0] = 25'h1842108;
        exp_w[1] = 25'h0108421;
        do_start();
        finish_run("slice0");

        // Single bit (0,0) in slice 63: its parity is the z-1 term of slice 0.
        clear_mem();
        mem[63]   = 25'h1000000;
        exp_w[63] = 25'h1842108;
        exp_w[0]  = 25'h0108421;
        do_start();
        finish_run("wrap");

        // Start pulses while busy are ignored.
        clear_mem();
        mem[0]   = 25'h1000000;
        exp_w[0] = 25'h1842108;
        exp_w[1] = 25'h0108421;
        do_start();
        while (cyc < t0 + 32'd4) @(negedge clk);
        check("busy_ready_lo", {31'd0, ready}, 32'd0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < t0 + 32'd29) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_run("restart");

        // Asynchronous reset mid-run, then a clean rerun.
        do_start();
        while (cyc < t0 + 32'd20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_ready", {31'd0, ready},     32'd1);
        check("async_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("async_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("async_done",  {31'd0, done},      32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        do_start();
        finish_run("post_rst");

`ifdef THETA_BYPASS_EN
        // Bypass writes every slice back unchanged.
        for (int z = 0; z < DEPTH; z++) begin
            mem[z]   = N'($urandom);
            exp_w[z] = mem[z];
        end
        bypass = 1'b1;
        do_start();
        bypass = 1'b0;
        finish_run("bypass");
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
